// File: rtl/time_set_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : time_set_pkg
//  Brief    : Field encoding, BCD limits and calendar helpers for time setting
//  Revision : 1.0
// ============================================================================
package time_set_pkg;

    typedef enum logic [2:0] {
        F_NONE  = 3'd0,
        F_HOUR  = 3'd1,
        F_MIN   = 3'd2,
        F_SEC   = 3'd3,
        F_DAY   = 3'd4,
        F_MONTH = 3'd5,
        F_YEAR  = 3'd6
    } field_e;

    localparam logic [7:0] HOUR_LO  = 8'h00;
    localparam logic [7:0] HOUR_HI  = 8'h23;
    localparam logic [7:0] MS_LO    = 8'h00;
    localparam logic [7:0] MS_HI    = 8'h59;
    localparam logic [7:0] MONTH_LO = 8'h01;
    localparam logic [7:0] MONTH_HI = 8'h12;
    localparam logic [7:0] DAY_LO   = 8'h01;
    localparam logic [7:0] BYTE_LO  = 8'h00;
    localparam logic [7:0] BYTE_HI  = 8'h99;

    // Plain unsigned compare is valid on BCD since digit order matches value order.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] val, input logic [7:0] lo,
                                            input logic [7:0] hi);
        logic [7:0] r;
        if (val >= hi)
            r = lo;
        else if (val[3:0] == 4'd9)
            r = {val[7:4] + 4'd1, 4'd0};
        else
            r = val + 8'd1;
        return r;
    endfunction

    function automatic logic [7:0] bcd2_dec(input logic [7:0] val, input logic [7:0] lo,
                                            input logic [7:0] hi);
        logic [7:0] r;
        if (val <= lo)
            r = hi;
        else if (val[3:0] == 4'd0)
            r = {val[7:4] - 4'd1, 4'd9};
        else
            r = val - 8'd1;
        return r;
    endfunction

    function automatic logic [6:0] bcd2bin(input logic [7:0] v);
        return ({3'd0, v[7:4]} * 7'd10) + {3'd0, v[3:0]};
    endfunction

    // A century year is leap only when its century number is divisible by 4.
    function automatic logic is_leap(input logic [15:0] year);
        logic [6:0] lo_b;
        logic [6:0] hi_b;
        lo_b = bcd2bin(year[7:0]);
        hi_b = bcd2bin(year[15:8]);
        return (lo_b == 7'd0) ? (hi_b[1:0] == 2'd0) : (lo_b[1:0] == 2'd0);
    endfunction

    function automatic logic [7:0] max_day(input logic [7:0] month, input logic leap);
        logic [7:0] r;
        case (month)
            8'h02:                      r = leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
            default:                    r = 8'h31;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] year_inc(input logic [15:0] y);
        if (y[7:0] == BYTE_HI)
            return {bcd2_inc(y[15:8], BYTE_LO, BYTE_HI), BYTE_LO};
        return {y[15:8], bcd2_inc(y[7:0], BYTE_LO, BYTE_HI)};
    endfunction

    function automatic logic [15:0] year_dec(input logic [15:0] y);
        if (y[7:0] == BYTE_LO)
            return {bcd2_dec(y[15:8], BYTE_LO, BYTE_HI), BYTE_HI};
        return {y[15:8], bcd2_dec(y[7:0], BYTE_LO, BYTE_HI)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_ctrl_button.sv
`default_nettype none
// ============================================================================
//  Module   : button_repeat
//  Brief    : Active-low button synchroniser, press detect and auto-repeat
//  Revision : 1.0
// ============================================================================
module button_repeat #(
    parameter int REPEAT_CYC = 12_500_000,
    parameter bit REPEAT_EN  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_butt_n,
    input  logic i_inhibit,
    output logic o_pulse,
    output logic o_held
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic w_fall;

    always_comb begin
        sync1_d = i_butt_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign w_fall = prev_q & ~sync2_q;
    assign o_held = ~sync2_q;

    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int CNT_W = $clog2(REPEAT_CYC + 1);
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             w_rep;

            // Counter value 0 means "no repeat armed"; it arms on the first press.
            always_comb begin
                cnt_d = cnt_q;
                w_rep = 1'b0;
                if (sync2_q || i_inhibit)
                    cnt_d = '0;
                else if (w_fall)
                    cnt_d = CNT_W'(1);
                else if (cnt_q == CNT_W'(REPEAT_CYC)) begin
                    cnt_d = CNT_W'(1);
                    w_rep = 1'b1;
                end else if (cnt_q != '0)
                    cnt_d = cnt_q + CNT_W'(1);
            end

            always_ff @(posedge clk) begin
                if (rst)
                    cnt_q <= '0;
                else
                    cnt_q <= cnt_d;
            end

            assign o_pulse = (w_fall | w_rep) & ~i_inhibit;
        end else begin : g_single
            assign o_pulse = w_fall & ~i_inhibit;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : time_set_ctrl
//  Brief    : Field-by-field edit controller for the BCD clock/calendar
//  Revision : 1.0
// ============================================================================
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int REPEAT_CYC  = 12_500_000,
    parameter int BLINK_CYC   = 25_000_000,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        butt_increase,
    input  logic        butt_decrease,
    input  logic        butt_change,
    input  logic [23:0] cur_time,
    input  logic [31:0] cur_date,
    output logic        set_active,
    output logic        load_en,
    output logic [23:0] load_time,
    output logic [31:0] load_date,
    output logic [2:0]  field,
    output logic        blink
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HOUR   = 3'd1;
    localparam logic [2:0] ST_MIN    = 3'd2;
    localparam logic [2:0] ST_SEC    = 3'd3;
    localparam logic [2:0] ST_DAY    = 3'd4;
    localparam logic [2:0] ST_MONTH  = 3'd5;
    localparam logic [2:0] ST_YEAR   = 3'd6;
    localparam logic [2:0] ST_COMMIT = 3'd7;

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int BL_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    logic [2:0]      state_q, state_d;
    logic [23:0]     time_q, time_d;
    logic [31:0]     date_q, date_d;
    logic            clamp_q, clamp_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
    logic            blink_q, blink_d;

    logic w_inc_pulse, w_dec_pulse, w_chg_pulse;
    logic w_inc_held, w_dec_held, w_chg_held;
    logic w_both, w_edit, w_chg, w_inc, w_dec, w_act, w_timeout;
    logic [7:0] w_maxday;

    assign w_both = w_inc_held & w_dec_held;

    button_repeat #(.REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1)) u_inc (
        .clk(clk), .rst(rst), .i_butt_n(butt_increase), .i_inhibit(w_both),
        .o_pulse(w_inc_pulse), .o_held(w_inc_held)
    );

    button_repeat #(.REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1)) u_dec (
        .clk(clk), .rst(rst), .i_butt_n(butt_decrease), .i_inhibit(w_both),
        .o_pulse(w_dec_pulse), .o_held(w_dec_held)
    );

    button_repeat #(.REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0)) u_chg (
        .clk(clk), .rst(rst), .i_butt_n(butt_change), .i_inhibit(1'b0),
        .o_pulse(w_chg_pulse), .o_held(w_chg_held)
    );

    // Change takes priority over a coincident inc/dec.
    assign w_edit    = (state_q != ST_IDLE) && (state_q != ST_COMMIT);
    assign w_chg     = w_chg_pulse;
    assign w_inc     = w_edit & w_inc_pulse & ~w_chg_pulse;
    assign w_dec     = w_edit & w_dec_pulse & ~w_chg_pulse;
    assign w_act     = w_edit & (w_chg | w_inc | w_dec);
    assign w_timeout = w_edit & ~w_act & (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
    assign w_maxday  = max_day(date_q[23:16], is_leap(date_q[15:0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            time_q   <= '0;
            date_q   <= '0;
            clamp_q  <= 1'b0;
            to_cnt_q <= '0;
            bl_cnt_q <= '0;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            date_q   <= date_d;
            clamp_q  <= clamp_d;
            to_cnt_q <= to_cnt_d;
            bl_cnt_q <= bl_cnt_d;
            blink_q  <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (w_chg) state_d = ST_HOUR;
            ST_COMMIT: state_d = ST_IDLE;
            default: begin
                if (w_timeout)
                    state_d = ST_IDLE;
                else if (w_chg)
                    state_d = (state_q == ST_YEAR) ? ST_COMMIT : state_q + 3'd1;
            end
        endcase
    end

    // Shadow registers: capture on entry, edit the active field, clamp the day
    // one cycle after month/year moved.
    always_comb begin
        time_d  = time_q;
        date_d  = date_q;
        clamp_d = 1'b0;
        if ((state_q == ST_IDLE) && w_chg) begin
            time_d = cur_time;
            date_d = cur_date;
        end else begin
            if (clamp_q && (date_q[31:24] > w_maxday))
                date_d[31:24] = w_maxday;
            if (w_inc || w_dec) begin
                case (state_q)
                    ST_HOUR:  time_d[23:16] = w_inc ? bcd2_inc(time_q[23:16], HOUR_LO, HOUR_HI)
                                                    : bcd2_dec(time_q[23:16], HOUR_LO, HOUR_HI);
                    ST_MIN:   time_d[15:8]  = w_inc ? bcd2_inc(time_q[15:8], MS_LO, MS_HI)
                                                    : bcd2_dec(time_q[15:8], MS_LO, MS_HI);
                    ST_SEC:   time_d[7:0]   = w_inc ? bcd2_inc(time_q[7:0], MS_LO, MS_HI)
                                                    : bcd2_dec(time_q[7:0], MS_LO, MS_HI);
                    ST_DAY:   date_d[31:24] = w_inc ? bcd2_inc(date_q[31:24], DAY_LO, w_maxday)
                                                    : bcd2_dec(date_q[31:24], DAY_LO, w_maxday);
                    ST_MONTH: begin
                        date_d[23:16] = w_inc ? bcd2_inc(date_q[23:16], MONTH_LO, MONTH_HI)
                                              : bcd2_dec(date_q[23:16], MONTH_LO, MONTH_HI);
                        clamp_d = 1'b1;
                    end
                    ST_YEAR: begin
                        date_d[15:0] = w_inc ? year_inc(date_q[15:0]) : year_dec(date_q[15:0]);
                        clamp_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (!w_edit || w_act || w_timeout)
            to_cnt_d = '0;

        bl_cnt_d = bl_cnt_q + BL_W'(1);
        blink_d  = blink_q;
        if (!w_edit || w_chg || w_inc || w_dec) begin
            bl_cnt_d = '0;
            blink_d  = 1'b0;
        end else if (bl_cnt_q == BL_W'(BLINK_CYC - 1)) begin
            bl_cnt_d = '0;
            blink_d  = ~blink_q;
        end
    end

    always_comb begin
        set_active = (state_q != ST_IDLE);
        load_en    = (state_q == ST_COMMIT);
        load_time  = time_q;
        load_date  = date_q;
        blink      = blink_q & w_edit;
        case (state_q)
            ST_HOUR:  field = F_HOUR;
            ST_MIN:   field = F_MIN;
            ST_SEC:   field = F_SEC;
            ST_DAY:   field = F_DAY;
            ST_MONTH: field = F_MONTH;
            ST_YEAR:  field = F_YEAR;
            default:  field = F_NONE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_set_ctrl
//  Brief    : Self-checking bench for time_set_ctrl (vectors, corner sequences, random)
//  Revision : 1.0
// ============================================================================
module tb_time_set_ctrl;

    localparam logic [2:0] M_INC = 3'b001;
    localparam logic [2:0] M_DEC = 3'b010;
    localparam logic [2:0] M_CHG = 3'b100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        butt_increase = 1'b1;
    logic        butt_decrease = 1'b1;
    logic        butt_change = 1'b1;
    logic [23:0] cur_time = '0;
    logic [31:0] cur_date = '0;
    logic        set_active, load_en, blink;
    logic [23:0] load_time;
    logic [31:0] load_date;
    logic [2:0]  field;

    int total = 0;
    int bad = 0;
    int load_cnt = 0;
    logic [23:0] last_lt = '0;
    logic [31:0] last_ld = '0;

    time_set_ctrl #(.REPEAT_CYC(10), .BLINK_CYC(8), .TIMEOUT_CYC(200)) dut (
        .clk(clk), .rst(rst),
        .butt_increase(butt_increase), .butt_decrease(butt_decrease), .butt_change(butt_change),
        .cur_time(cur_time), .cur_date(cur_date),
        .set_active(set_active), .load_en(load_en),
        .load_time(load_time), .load_date(load_date),
        .field(field), .blink(blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_en) begin
            load_cnt <= load_cnt + 1;
            last_lt  <= load_time;
            last_ld  <= load_date;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Caller is 1 time unit after a rising edge; the action lands on the 3rd edge.
    task automatic press(input logic [2:0] m, input int hold);
        butt_increase = ~m[0];
        butt_decrease = ~m[1];
        butt_change   = ~m[2];
        repeat (hold) @(posedge clk);
        #1;
        butt_increase = 1'b1;
        butt_decrease = 1'b1;
        butt_change   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference (plain integers) ----------------
    int h, mi, s, d, mo, y, fld, exp_loads;
    int ch, cm, cs, cd, cmo, cy;

    function automatic int maxd(input int m, input int yr);
        bit lp;
        lp = (yr % 4 == 0) && ((yr % 100 != 0) || (yr % 400 == 0));
        if (m == 2) return lp ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic logic [7:0] b2(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic model_step(input int op);
        int dl, md;
        if (op == 2) begin
            if (fld == 0) begin
                h = ch; mi = cm; s = cs; d = cd; mo = cmo; y = cy; fld = 1;
            end else if (fld == 6) begin
                fld = 0;
                exp_loads++;
            end else
                fld++;
        end else if (fld != 0) begin
            dl = (op == 0) ? 1 : -1;
            case (fld)
                1: h  = (h + 24 + dl) % 24;
                2: mi = (mi + 60 + dl) % 60;
                3: s  = (s + 60 + dl) % 60;
                4: begin
                    md = maxd(mo, y);
                    if (op == 0) d = (d >= md) ? 1 : d + 1;
                    else         d = (d <= 1) ? md : d - 1;
                end
                5: mo = ((mo - 1 + 12 + dl) % 12) + 1;
                default: y = (y + 10000 + dl) % 10000;
            endcase
            if ((fld == 5 || fld == 6) && d > maxd(mo, y)) d = maxd(mo, y);
        end
    endtask

    typedef struct {
        logic [23:0] t;
        logic [31:0] dt;
        int          f;
        bit          up;
        logic [23:0] et;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int base, op, nl;
        vecs[0]  = '{24'h230000, 32'h01012000, 1, 1'b1, 24'h000000, 32'h01012000};
        vecs[1]  = '{24'h001020, 32'h01012000, 1, 1'b0, 24'h231020, 32'h01012000};
        vecs[2]  = '{24'h105900, 32'h01012000, 2, 1'b1, 24'h100000, 32'h01012000};
        vecs[3]  = '{24'h100000, 32'h15122020, 5, 1'b1, 24'h100000, 32'h15012020};
        vecs[4]  = '{24'h100000, 32'h15069999, 6, 1'b1, 24'h100000, 32'h15060000};
        vecs[5]  = '{24'h100000, 32'h01042021, 4, 1'b0, 24'h100000, 32'h30042021};
        vecs[6]  = '{24'h100000, 32'h31012023, 5, 1'b1, 24'h100000, 32'h28022023};
        vecs[7]  = '{24'h100000, 32'h29022024, 6, 1'b1, 24'h100000, 32'h28022025};
        vecs[8]  = '{24'h100000, 32'h28021900, 4, 1'b1, 24'h100000, 32'h01021900};
        vecs[9]  = '{24'h100000, 32'h28022000, 4, 1'b1, 24'h100000, 32'h29022000};
        vecs[10] = '{24'h100000, 32'h10012000, 3, 1'b0, 24'h100059, 32'h10012000};
        vecs[11] = '{24'h100000, 32'h10012000, 5, 1'b0, 24'h100000, 32'h10122000};
        vecs[12] = '{24'h100000, 32'h10010000, 6, 1'b0, 24'h100000, 32'h10019999};
        vecs[13] = '{24'h100000, 32'h31032021, 5, 1'b0, 24'h100000, 32'h28022021};

        // Reset state
        cycles(3);
        chk("reset_ctrl", {28'd0, set_active, load_en, field, blink}, 32'd0);
        chk("reset_time", {8'd0, load_time}, 32'd0);
        chk("reset_date", load_date, 32'd0);
        rst = 1'b0;
        cycles(2);

        // Full walk: 12:34:56 15-06-2024, HOUR inc, commit
        cur_time = 24'h123456;
        cur_date = 32'h15062024;
        press(M_CHG, 3);
        chk("walk_field1", 32'(field), 32'd1);
        chk("walk_active", 32'(set_active), 32'd1);
        press(M_INC, 3);
        for (int i = 0; i < 6; i++) begin
            press(M_CHG, 3);
            chk("walk_field", 32'(field), (i < 5) ? 32'(i + 2) : 32'd0);
        end
        chk("walk_loads", 32'(load_cnt), 32'd1);
        chk("walk_ltime", {8'd0, last_lt}, 32'h00133456);
        chk("walk_ldate", last_ld, 32'h15062024);
        chk("walk_idle_active", 32'(set_active), 32'd0);

        // Table vectors: wrap, leap and clamp cases
        for (int v = 0; v < 14; v++) begin
            cur_time = vecs[v].t;
            cur_date = vecs[v].dt;
            nl = load_cnt;
            for (int k = 0; k < vecs[v].f; k++) press(M_CHG, 3);
            chk("vec_field", 32'(field), 32'(vecs[v].f));
            press(vecs[v].up ? M_INC : M_DEC, 3);
            chk("vec_time", {8'd0, load_time}, {8'd0, vecs[v].et});
            chk("vec_date", load_date, vecs[v].ed);
            for (int k = 0; k < 7 - vecs[v].f; k++) press(M_CHG, 3);
            chk("vec_load_count", 32'(load_cnt - nl), 32'd1);
            chk("vec_load_date", last_ld, vecs[v].ed);
        end

        // Held inc in SEC: first step plus three repeats
        cur_time = 24'h101000;
        cur_date = 32'h01012000;
        for (int k = 0; k < 3; k++) press(M_CHG, 3);
        press(M_INC, 37);
        chk("hold_sec", {24'd0, load_time[7:0]}, 32'h04);
        cycles(20);
        chk("hold_release", {24'd0, load_time[7:0]}, 32'h04);
        for (int k = 0; k < 4; k++) press(M_CHG, 3);
        chk("hold_exit_field", 32'(field), 32'd0);

        // Blink cadence, then timeout without a load
        nl = load_cnt;
        press(M_CHG, 3);
        base = 0;
        for (int k = 0; k < 32; k++) begin
            cycles(1);
            base += int'(blink);
        end
        chk("blink_high_cycles", 32'(base), 32'd16);
        cycles(100);
        chk("timeout_still_edit", 32'(field), 32'd1);
        cycles(80);
        chk("timeout_field", 32'(field), 32'd0);
        chk("timeout_active", 32'(set_active), 32'd0);
        chk("timeout_no_load", 32'(load_cnt - nl), 32'd0);

        // Simultaneous buttons and reset mid-edit
        cur_time = 24'h123456;
        press(M_CHG, 3);
        press(M_CHG, 3);
        press(M_INC | M_DEC, 15);
        chk("incdec_min", {8'd0, load_time}, 32'h00123456);
        chk("incdec_field", 32'(field), 32'd2);
        press(M_CHG | M_INC, 3);
        chk("chginc_field", 32'(field), 32'd3);
        chk("chginc_time", {8'd0, load_time}, 32'h00123456);
        for (int k = 0; k < 3; k++) press(M_CHG, 3);
        chk("pre_rst_field", 32'(field), 32'd6);
        nl = load_cnt;
        rst = 1'b1;
        cycles(1);
        chk("rst_ctrl", {28'd0, set_active, load_en, field, blink}, 32'd0);
        chk("rst_shadow", {8'd0, load_time} | load_date, 32'd0);
        rst = 1'b0;
        cycles(2);
        chk("rst_no_load", 32'(load_cnt - nl), 32'd0);

        // Randomised press sequences against the integer model
        fld = 0;
        exp_loads = 0;
        base = load_cnt;
        for (int r = 0; r < 6; r++) begin
            while (fld != 0) begin
                press(M_CHG, 3);
                model_step(2);
            end
            ch  = $urandom_range(0, 23);
            cm  = $urandom_range(0, 59);
            cs  = $urandom_range(0, 59);
            cy  = (r == 0) ? 9999 : $urandom_range(0, 9999);
            cmo = $urandom_range(1, 12);
            cd  = $urandom_range(1, maxd(cmo, cy));
            cur_time = {b2(ch), b2(cm), b2(cs)};
            cur_date = {b2(cd), b2(cmo), b2(cy / 100), b2(cy % 100)};
            for (int j = 0; j < 25; j++) begin
                op = $urandom_range(0, 9);
                op = (j == 0) ? 2 : (op < 4) ? 0 : (op < 8) ? 1 : 2;
                press((op == 0) ? M_INC : (op == 1) ? M_DEC : M_CHG, 3);
                model_step(op);
                chk("rnd_field", 32'(field), 32'(fld));
                chk("rnd_time", {8'd0, load_time}, {8'd0, b2(h), b2(mi), b2(s)});
                chk("rnd_date", load_date, {b2(d), b2(mo), b2(y / 100), b2(y % 100)});
                chk("rnd_blink", 32'(blink), 32'd0);
                chk("rnd_loads", 32'(load_cnt - base), 32'(exp_loads));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
